// File: rtl/wt_inval_queue.sv
// Snoop invalidation FIFO feeding line-aligned invalidations to the WT cache.
// Optional coalescing of duplicate lines: define WT_INVAL_DEDUP_EN.
package config_pkg;
  typedef struct packed {
    int unsigned XLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '0;
endpackage

module wt_inval_queue #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned Depth = 4,
  parameter int unsigned LineOffset = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [63:0]                snoop_addr_i,
  input  logic                       snoop_valid_i,
  output logic                       snoop_ready_o,
  output logic [63:0]                inval_addr_o,
  output logic                       inval_valid_o,
  input  logic                       inval_ready_i,
  input  logic                       flush_i,
  output logic [$clog2(Depth):0]     level_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(Depth);
  localparam logic [63:0] Mask =
    ~((64'd1 << LineOffset) - 64'd1);

  logic [63:0]   mem_q [Depth];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] cnt_q;
  logic [63:0]   line;
  logic          push;
  logic          pop;
  logic          store;
  logic          unused_cfg;

  assign unused_cfg = ^CVA6Cfg;
  assign line = snoop_addr_i & Mask;

  assign snoop_ready_o = (cnt_q != Full) && !flush_i;
  assign inval_valid_o = (cnt_q != '0) && !flush_i;
  assign inval_addr_o  = inval_valid_o ? mem_q[rptr_q] : '0;
  assign level_o       = cnt_q;

  assign push = snoop_valid_i && snoop_ready_o;
  assign pop  = inval_valid_o && inval_ready_i;

`ifdef WT_INVAL_DEDUP_EN
  logic [Depth-1:0] vld_q;
  logic [15:0]      drop_q;
  logic             hit;
  logic             dup;

  // The head leaving this cycle no longer covers a new snoop.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (vld_q[i] && mem_q[i] == line &&
          !(pop && AW'(i) == rptr_q)) begin
        hit = 1'b1;
      end
    end
  end

  assign dup        = push && hit;
  assign store      = push && !hit;
  assign drop_cnt_o = drop_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      drop_q <= '0;
    end else if (flush_i) begin
      vld_q  <= '0;
    end else begin
      if (store) vld_q[wptr_q] <= 1'b1;
      if (pop)   vld_q[rptr_q] <= 1'b0;
      if (dup && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end
`else
  assign store      = push;
  assign drop_cnt_o = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (store) mem_q[wptr_q] <= line;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (store) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(store) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_wt_inval_queue.sv
// Scoreboard bench for wt_inval_queue (Depth=4, LineOffset=4).
// Follows WT_INVAL_DEDUP_EN to pick coalescing expectations.
module tb_wt_inval_queue;

  localparam int Depth = 4;
`ifdef WT_INVAL_DEDUP_EN
  localparam bit Dedup = 1'b1;
`else
  localparam bit Dedup = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] snoop_addr = '0;
  logic        snoop_valid = 1'b0;
  logic        snoop_ready;
  logic [63:0] inval_addr;
  logic        inval_valid;
  logic        inval_ready = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  level;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail = 0;
  logic [63:0] mq [$];
  int unsigned mdrop = 0;
  bit done = 1'b0;

  always #5 clk = ~clk;

  wt_inval_queue #(
    .Depth      (Depth),
    .LineOffset (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .snoop_addr_i  (snoop_addr),
    .snoop_valid_i (snoop_valid),
    .snoop_ready_o (snoop_ready),
    .inval_addr_o  (inval_addr),
    .inval_valid_o (inval_valid),
    .inval_ready_i (inval_ready),
    .flush_i       (flush),
    .level_o       (level),
    .drop_cnt_o    (drop_cnt)
  );

  function automatic logic [63:0] line_of(logic [63:0] a);
    return a & ~64'hF;
  endfunction

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(bit v, logic [63:0] a, bit r, bit f);
    snoop_valid = v;
    snoop_addr  = a;
    inval_ready = r;
    flush       = f;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    snoop_addr  = '0;
    flush       = 1'b0;
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_ready"}, 64'(snoop_ready), 64'd1);
    chk({tag, "_valid"}, 64'(inval_valid), 64'd0);
    chk({tag, "_addr"}, inval_addr, 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_drop"}, 64'(drop_cnt), 64'd0);
  endtask

  // Checks outputs against the model, then advances the model for
  // the coming edge using the inputs that edge will sample.
  initial begin
    bit exp_v, exp_r, pop, push, hit;
    logic [63:0] l;
    forever begin
      @(negedge clk);
      if (done) break;
      if (!rst_n) begin
        mq.delete();
        mdrop = 0;
      end
      exp_v = mq.size() != 0 && !flush;
      exp_r = mq.size() != Depth && !flush;
      chk("level", 64'(level), 64'(mq.size()));
      chk("snoop_ready", 64'(snoop_ready), 64'(exp_r));
      chk("inval_valid", 64'(inval_valid), 64'(exp_v));
      if (exp_v) chk("inval_addr", inval_addr, mq[0]);
      chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
      if (rst_n) begin
        if (flush) begin
          mq.delete();
        end else begin
          pop  = exp_v && inval_ready;
          push = exp_r && snoop_valid;
          l    = line_of(snoop_addr);
          hit  = 1'b0;
          if (Dedup) begin
            foreach (mq[j]) begin
              if (mq[j] == l && !(pop && j == 0)) hit = 1'b1;
            end
          end
          if (pop) void'(mq.pop_front());
          if (push) begin
            if (hit) begin
              if (mdrop != 32'hFFFF) mdrop++;
            end else begin
              mq.push_back(l);
            end
          end
        end
      end
    end
  end

  initial begin
    #3;
    reset_checks("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // basic flow
    step(1'b1, 64'h8000_1234, 1'b1, 1'b0);
    chk("basic_valid", 64'(inval_valid), 64'd1);
    chk("basic_addr", inval_addr, 64'h8000_1230);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("basic_level", 64'(level), 64'd0);

    // fill, then wrap the pointers with pop/push traffic
    for (int i = 0; i < Depth; i++) begin
      step(1'b1, 64'h1000 * (i + 1) + 64'(i * 3), 1'b0, 1'b0);
    end
    chk("full_ready", 64'(snoop_ready), 64'd0);
    chk("full_level", 64'(level), 64'd4);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 64'h2_0000 + 64'h40 * i + 64'd7, 1'b1, 1'b0);
    end
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);

    // simultaneous push and pop at level 2
    step(1'b1, 64'h3000, 1'b0, 1'b0);
    step(1'b1, 64'h3100, 1'b0, 1'b0);
    step(1'b1, 64'h3200, 1'b1, 1'b0);
    chk("simul_level", 64'(level), 64'd2);
    chk("simul_head", inval_addr, 64'h3100);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // coalescing, then a match against the entry being popped
    step(1'b1, 64'h100, 1'b0, 1'b0);
    step(1'b1, 64'h108, 1'b0, 1'b0);
    chk("coal_level", 64'(level), Dedup ? 64'd1 : 64'd2);
    chk("coal_drop", 64'(drop_cnt), Dedup ? 64'd1 : 64'd0);
    step(1'b1, 64'h10C, 1'b1, 1'b0);
    chk("popmatch_level", 64'(level), Dedup ? 64'd1 : 64'd2);
    repeat (3) step(1'b0, '0, 1'b1, 1'b0);

    // flush at level 3 discards a concurrent push and pop
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'h5000 + 64'h100 * i, 1'b0, 1'b0);
    end
    chk("preflush_level", 64'(level), 64'd3);
    step(1'b1, 64'h6000, 1'b1, 1'b1);
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_valid", 64'(inval_valid), 64'd0);

    // asynchronous reset while stalled
    inval_ready = 1'b0;
    step(1'b1, 64'h7000, 1'b0, 1'b0);
    step(1'b1, 64'h7100, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mq.delete();
    mdrop = 0;
    #1;
    reset_checks("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) step(1'b0, '0, 1'b1, 1'b0);
    chk("postrst_valid", 64'(inval_valid), 64'd0);

    // random traffic over a few nearby lines
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)),
           64'h100 + 64'($urandom_range(0, 63)),
           1'($urandom_range(0, 2) != 0),
           $urandom_range(0, 24) == 0);
    end
    repeat (6) step(1'b0, '0, 1'b1, 1'b0);
    chk("end_level", 64'(level), 64'd0);

    done = 1'b1;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
